pfiform_pop_unpacker: RTL and testbench

//  Consumer (reader) side of the PFIFORM pop interface. Accepts packed pop words
//  (PopAmout+1 elements of ELEM_W bits each) through the PopEnable/PopPermit handshake.

---
 rtl/pfiform_pop_unpacker.sv | 115 +++++++++++
 tb/tb_pfiform_pop_unpacker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pfiform_pop_unpacker.sv
// pfiform_pop_unpacker: consumer side of the PFIFORM pop port.
// Accepts packed words (PopAmout+1 elements) via PopEnable/PopPermit, buffers up to
// two words and emits one element per cycle on a valid/ready stream.
// Optional macro PFIFORM_UNPACK_SEQCHK_EN adds a sticky element-sequence checker.
module pfiform_pop_unpacker #(
  parameter int unsigned ELEM_W    = 6,
  parameter int unsigned MAX_ELEMS = 32,
  parameter int unsigned AMT_W     = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        i_core_clk,
  input  logic                        i_rx_rstn,
  input  logic                        PopEnable,
  output logic                        PopPermit,
  input  logic [AMT_W-1:0]            PopAmout,
  input  logic [ELEM_W*MAX_ELEMS-1:0] PopData,
  output logic [ELEM_W-1:0]           o_elem_data,
  output logic                        o_elem_valid,
  output logic                        o_elem_last,
  input  logic                        i_elem_ready,
  output logic [CNT_W-1:0]            o_word_cnt,
  output logic                        o_seq_err
);

  localparam int unsigned DataW = ELEM_W * MAX_ELEMS;

  logic [DataW-1:0] r_data [2];
  logic [AMT_W-1:0] r_amt  [2];
  logic             r_head;
  logic [1:0]       r_cnt;
  logic [AMT_W-1:0] r_idx;
  logic             r_permit;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_push;
  logic             w_valid;
  logic             w_at_last;
  logic             w_take;
  logic             w_pop;
  logic             w_tail;
  logic [1:0]       w_cnt_nxt;
  logic [ELEM_W-1:0] w_elem;

  // Handshake decode and buffer occupancy after this edge
  always_comb begin
    w_push    = PopEnable & r_permit;
    w_valid   = (r_cnt != 2'd0);
    w_at_last = (r_idx == r_amt[r_head]);
    w_take    = w_valid & i_elem_ready;
    w_pop     = w_take & w_at_last;
    // With one word held the free slot is the other one; when empty it is the head slot
    w_tail    = r_head ^ r_cnt[0];
    w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    w_elem    = r_data[r_head][r_idx*ELEM_W +: ELEM_W];
  end

  // Word storage: payload only, occupancy is tracked separately
  always_ff @(posedge i_core_clk) begin
    if (w_push) begin
      r_data[w_tail] <= PopData;
      r_amt[w_tail]  <= PopAmout;
    end
  end

  // Buffer control, unpack index, permit and word counter
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_head     <= 1'b0;
      r_cnt      <= 2'd0;
      r_idx      <= '0;
      r_permit   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_permit <= (w_cnt_nxt < 2'd2);
      if (w_push) r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_pop) begin
        r_head <= ~r_head;
        r_idx  <= '0;
      end else if (w_take) begin
        r_idx <= r_idx + AMT_W'(1);
      end
    end
  end

  // Stream outputs; data forced to zero when nothing is held so reset shows zeros
  always_comb begin
    o_elem_valid = w_valid;
    o_elem_last  = w_valid & w_at_last;
    o_elem_data  = w_valid ? w_elem : '0;
    PopPermit    = r_permit;
    o_word_cnt   = r_word_cnt;
  end

`ifdef PFIFORM_UNPACK_SEQCHK_EN
  logic [ELEM_W-1:0] r_exp;
  logic              r_seq_err;

  // Sequence checker: expectation resyncs to each consumed element
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_exp     <= '0;
      r_seq_err <= 1'b0;
    end else if (w_take) begin
      r_exp <= w_elem + ELEM_W'(1);
      if (w_elem != r_exp) r_seq_err <= 1'b1;
    end
  end

  assign o_seq_err = r_seq_err;
`else
  assign o_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_pfiform_pop_unpacker.sv
// Bench for pfiform_pop_unpacker: directed phases with random data/ready, checked
// every cycle against an element-queue model of the expected stream.
module tb_pfiform_pop_unpacker;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         pop_en = 1'b0;
  logic         pop_permit;
  logic [4:0]   pop_amt = '0;
  logic [191:0] pop_data = '0;
  logic [5:0]   elem_data;
  logic         elem_valid;
  logic         elem_last;
  logic         elem_ready = 1'b0;
  logic [15:0]  word_cnt;
  logic         seq_err;

  int errors = 0;
  int checks = 0;

  // Model: expected elements as {last, data}, plus expected permit/count/error
  logic [6:0]  m_q[$];
  logic        m_perm = 1'b0;
  logic [15:0] m_wcnt = '0;
  logic        m_err = 1'b0;
  logic [5:0]  m_exp = '0;

  always #5 clk = ~clk;

  pfiform_pop_unpacker dut (
    .i_core_clk  (clk),
    .i_rx_rstn   (rstn),
    .PopEnable   (pop_en),
    .PopPermit   (pop_permit),
    .PopAmout    (pop_amt),
    .PopData     (pop_data),
    .o_elem_data (elem_data),
    .o_elem_valid(elem_valid),
    .o_elem_last (elem_last),
    .i_elem_ready(elem_ready),
    .o_word_cnt  (word_cnt),
    .o_seq_err   (seq_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int words_held();
    int n = 0;
    foreach (m_q[i]) if (m_q[i][6]) n++;
    return n;
  endfunction

  task automatic check_outputs();
    chk("valid", {31'b0, elem_valid}, {31'b0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      chk("data", {26'b0, elem_data}, {26'b0, m_q[0][5:0]});
      chk("last", {31'b0, elem_last}, {31'b0, m_q[0][6]});
    end else begin
      chk("last_idle", {31'b0, elem_last}, 32'd0);
    end
    chk("permit", {31'b0, pop_permit}, {31'b0, m_perm});
    chk("word_cnt", {16'b0, word_cnt}, {16'b0, m_wcnt});
    chk("seq_err", {31'b0, seq_err}, {31'b0, m_err});
  endtask

  // Apply inputs for the coming edge, advance the model, check after the edge
  task automatic step(input logic en, input logic [4:0] amt, input logic [191:0] data,
                      input logic rdy);
    logic [6:0] e;
    pop_en     = en;
    pop_amt    = amt;
    pop_data   = data;
    elem_ready = rdy;
    if (rstn) begin
      if (rdy && m_q.size() != 0) begin
        e = m_q.pop_front();
`ifdef PFIFORM_UNPACK_SEQCHK_EN
        if (e[5:0] != m_exp) m_err = 1'b1;
        m_exp = e[5:0] + 6'd1;
`endif
      end
      if (en && m_perm) begin
        for (int k = 0; k <= int'(amt); k++) m_q.push_back({k == int'(amt), data[k*6 +: 6]});
        m_wcnt = m_wcnt + 16'd1;
      end
      m_perm = (words_held() < 2);
    end else begin
      m_perm = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [191:0] rand_word();
    logic [191:0] w;
    for (int k = 0; k < 6; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [191:0] ramp_word(input int first);
    logic [191:0] w = '0;
    for (int k = 0; k < 32; k++) w[k*6 +: 6] = 6'(first + k);
    return w;
  endfunction

  // Wait (bounded) for permit, then offer one word for exactly the accepting cycle
  task automatic send(input logic [4:0] amt, input logic [191:0] data, input bit rnd_rdy);
    int n = 0;
    while (!m_perm && n < 100) begin
      step(1'b0, amt, data, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("send_permit", {31'b0, pop_permit}, 32'd1);
    step(1'b1, amt, data, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  initial begin
    logic [191:0] w;
    int n;

    // Reset held, then released
    @(negedge clk);
    check_outputs();
    repeat (5) step(1'b0, 5'd0, '0, 1'b0);
    rstn = 1'b1;
    step(1'b0, 5'd0, '0, 1'b0);
    chk("t1_permit_after_release", {31'b0, pop_permit}, 32'd1);

    // Single 23-element ramp word, ready held high
    send(5'd22, ramp_word(0), 1'b0);
    repeat (23) step(1'b0, 5'd0, '0, 1'b1);
    chk("t2_word_cnt", {16'b0, word_cnt}, 32'd1);
    chk("t2_drained", {31'b0, elem_valid}, 32'd0);

    // Producer holds PopEnable with downstream stalled: only two words fit
    w = rand_word();
    repeat (5) step(1'b1, 5'd7, w, 1'b0);
    chk("t3_word_cnt", {16'b0, word_cnt}, 32'd3);
    chk("t3_permit_full", {31'b0, pop_permit}, 32'd0);
    repeat (18) step(1'b0, 5'd7, w, 1'b1);
    chk("t3_drained", {31'b0, elem_valid}, 32'd0);

    // Back-to-back words with random ready, then a full 32-lane word
    send(5'd6, rand_word(), 1'b1);
    send(5'd18, rand_word(), 1'b1);
    send(5'd31, rand_word(), 1'b1);
    n = 0;
    while (m_q.size() != 0 && n < 300) begin
      step(1'b0, 5'd0, '0, 1'($urandom_range(0, 1)));
      n++;
    end
    chk("t4_drained", {31'b0, elem_valid}, 32'd0);
    chk("t4_word_cnt", {16'b0, word_cnt}, 32'd6);

    // Reset mid-word after ten elements consumed
    send(5'd22, ramp_word(0), 1'b0);
    repeat (10) step(1'b0, 5'd0, '0, 1'b1);
    rstn = 1'b0;
    #1;
    m_q.delete();
    m_perm = 1'b0;
    m_wcnt = '0;
    m_err  = 1'b0;
    m_exp  = '0;
    check_outputs();
    repeat (3) step(1'b0, 5'd0, '0, 1'b1);
    rstn = 1'b1;
    repeat (5) step(1'b0, 5'd0, '0, 1'b1);
    chk("t5_word_cnt", {16'b0, word_cnt}, 32'd0);
    chk("t5_no_stale", {31'b0, elem_valid}, 32'd0);

    // Stream 0,1,2,3,5,6 with a gap
    w = '0;
    w[5:0] = 6'd0; w[11:6] = 6'd1; w[17:12] = 6'd2;
    w[23:18] = 6'd3; w[29:24] = 6'd5; w[35:30] = 6'd6;
    send(5'd5, w, 1'b0);
    repeat (8) step(1'b0, 5'd0, '0, 1'b1);
`ifdef PFIFORM_UNPACK_SEQCHK_EN
    chk("t6_seq_err", {31'b0, seq_err}, 32'd1);
`else
    chk("t6_seq_err", {31'b0, seq_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
